prog_mem_ctrl: RTL

PROG_MEM_CTRL -- requirements
Module: prog_mem_ctrl

---
 rtl/prog_mem_pkg.sv | 13 +
 rtl/prog_mem_ctrl_if.sv | 26 ++
 rtl/prog_mem_dpram.sv | 44 ++++
 rtl/prog_mem_ctrl.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/prog_mem_pkg.sv
// Shared definitions for the program-memory controller: run-control state
// encoding and the saturation limit of the run-cycle counter.
package prog_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [31:0] CYCLE_CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/prog_mem_ctrl_if.sv
// Host request/return bus of the program-memory controller; the host side
// uses the master modport, the controller the slave modport.
interface prog_mem_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
);

    logic              i_h_valid;
    logic              i_h_we;
    logic [ADDR_W-1:0] i_h_addr;
    logic [DATA_W-1:0] i_h_wdata;
    logic              o_h_ready;
    logic              o_h_rvalid;
    logic [DATA_W-1:0] o_h_rdata;

    modport master (
        output i_h_valid, i_h_we, i_h_addr, i_h_wdata,
        input  o_h_ready, o_h_rvalid, o_h_rdata
    );

    modport slave (
        input  i_h_valid, i_h_we, i_h_addr, i_h_wdata,
        output o_h_ready, o_h_rvalid, o_h_rdata
    );

endinterface

// File: rtl/prog_mem_dpram.sv
// True dual-port word memory: port A serves the host, port B the CPU.
// Both reads are registered and return the pre-write word on a collision.
module prog_mem_dpram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_en,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic [DATA_W-1:0] b_rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Storage itself is never reset so program images survive a controller reset.
    always_ff @(posedge clk) begin
        if (a_we) begin
            mem[a_addr] <= a_wdata;
        end
        if (b_we) begin
            mem[b_addr] <= b_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_rdata <= '0;
            b_rdata <= '0;
        end else begin
            if (a_en) begin
                a_rdata <= mem[a_addr];
            end
            b_rdata <= mem[b_addr];
        end
    end

endmodule

// File: rtl/prog_mem_ctrl.sv
// Program-memory controller: host load/readback, CPU run control and exit code.
// Define PROG_MEM_CYCLE_CNT_EN to build the saturating RUN-cycle counter.
module prog_mem_ctrl
    import prog_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
) (
    input  logic              i_clk,
    input  logic              i_rst,
    prog_mem_ctrl_if.slave    host,
    input  logic              i_h_start,
    input  logic              i_h_halt,
    input  logic              i_h_clr,
    input  logic              i_c_we,
    input  logic [ADDR_W-1:0] i_c_addr,
    input  logic [DATA_W-1:0] i_c_wdata,
    output logic [DATA_W-1:0] o_c_rdata,
    output logic              o_cpu_run,
    output logic [1:0]        o_state,
    output logic [DATA_W-1:0] o_exit_code,
    output logic [31:0]       o_cycle_cnt
);

    localparam logic [ADDR_W-1:0] HALT_ADDR = '1;

    state_t            state;
    logic              h_ready_q;
    logic              cpu_run_q;
    logic              h_rvalid_q;
    logic [DATA_W-1:0] exit_code_q;
    logic              h_accept;
    logic              c_halt_wr;
    logic              c_mem_we;

    assign h_accept  = host.i_h_valid & h_ready_q;
    assign c_halt_wr = cpu_run_q & i_c_we & (i_c_addr == HALT_ADDR);
    assign c_mem_we  = cpu_run_q & i_c_we & (i_c_addr != HALT_ADDR);

    // Ready and run are registered copies of the next state, so the host is
    // stalled for exactly the cycles in which the CPU owns the clock enable.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            h_ready_q <= 1'b1;
            cpu_run_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_h_start) begin
                        state     <= ST_RUN;
                        h_ready_q <= 1'b0;
                        cpu_run_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (i_h_halt || c_halt_wr) begin
                        state     <= ST_HALT;
                        h_ready_q <= 1'b1;
                        cpu_run_q <= 1'b0;
                    end
                end
                ST_HALT: begin
                    if (i_h_clr) begin
                        state <= ST_IDLE;
                    end else if (i_h_start) begin
                        state     <= ST_RUN;
                        h_ready_q <= 1'b0;
                        cpu_run_q <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    h_ready_q <= 1'b1;
                    cpu_run_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            h_rvalid_q <= 1'b0;
        end else begin
            h_rvalid_q <= h_accept & ~host.i_h_we;
        end
    end

    // The all-ones CPU address is a mailbox, not storage.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            exit_code_q <= '0;
        end else if (c_halt_wr) begin
            exit_code_q <= i_c_wdata;
        end else if (state == ST_HALT && i_h_clr) begin
            exit_code_q <= '0;
        end
    end

`ifdef PROG_MEM_CYCLE_CNT_EN
    logic [31:0] cycle_cnt_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cycle_cnt_q <= '0;
        end else if (state == ST_RUN && cycle_cnt_q != CYCLE_CNT_MAX) begin
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
        end else if (state == ST_HALT && i_h_clr) begin
            cycle_cnt_q <= '0;
        end
    end

    assign o_cycle_cnt = cycle_cnt_q;
`else
    assign o_cycle_cnt = '0;
`endif

    prog_mem_dpram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_dpram (
        .clk     (i_clk),
        .rst     (i_rst),
        .a_en    (h_accept & ~host.i_h_we),
        .a_we    (h_accept & host.i_h_we),
        .a_addr  (host.i_h_addr),
        .a_wdata (host.i_h_wdata),
        .a_rdata (host.o_h_rdata),
        .b_we    (c_mem_we),
        .b_addr  (i_c_addr),
        .b_wdata (i_c_wdata),
        .b_rdata (o_c_rdata)
    );

    assign host.o_h_ready  = h_ready_q;
    assign host.o_h_rvalid = h_rvalid_q;
    assign o_cpu_run       = cpu_run_q;
    assign o_state         = state;
    assign o_exit_code     = exit_code_q;

endmodule
